// File: rtl/conv2d_read_arbiter_pkg.sv
// Shared types and constants for the conv2D read-path arbiter.
package conv2d_read_arbiter_pkg;

    // Arbiter states; the encoding is fixed so debug tooling can decode it.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2
    } arb_state_e;

    localparam int unsigned DefaultLwidth = 32;

    // Width of a client index; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module rr_priority_pick
    import conv2d_read_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDW     = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     idx,
    output logic               any_valid
);

    // Two passes: the upper segment [ptr, NUM_REQ) first, then the wrapped segment [0, ptr).
    always_comb begin
        idx       = '0;
        any_valid = 1'b0;
        for (int c = 0; c < NUM_REQ; c++) begin
            if (!any_valid && req[c] && (c >= int'(ptr))) begin
                any_valid = 1'b1;
                idx       = IDW'(c);
            end
        end
        // Reached only if nothing at or above ptr was requesting.
        for (int c = 0; c < NUM_REQ; c++) begin
            if (!any_valid && req[c]) begin
                any_valid = 1'b1;
                idx       = IDW'(c);
            end
        end
    end

    // One-hot form of the chosen index.
    always_comb begin
        gnt = '0;
        for (int c = 0; c < NUM_REQ; c++) begin
            gnt[c] = any_valid && (idx == IDW'(c));
        end
    end

endmodule

// File: rtl/conv2d_read_arbiter.sv
// Round-robin arbiter sharing one io_mem read path (address + data) among NUM_REQ engines.
// One burst is outstanding at a time and stays locked to its owner until the last beat.
module conv2d_read_arbiter
    import conv2d_read_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned AWIDTH  = 32,
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned LWIDTH  = DefaultLwidth
) (
    input  logic                        clk,
    input  logic                        rst,
    // Client side
    input  logic [NUM_REQ*AWIDTH-1:0]   cli_read_addr,
    input  logic [NUM_REQ-1:0]          cli_read_addr_valid,
    output logic [NUM_REQ-1:0]          cli_read_addr_ready,
    input  logic [NUM_REQ*LWIDTH-1:0]   cli_read_len,
    output logic [DWIDTH-1:0]           cli_rdata,
    output logic [NUM_REQ-1:0]          cli_rdata_valid,
    input  logic [NUM_REQ-1:0]          cli_rdata_ready,
    // Memory side
    output logic [AWIDTH-1:0]           req_read_addr,
    output logic                        req_read_addr_valid,
    input  logic                        req_read_addr_ready,
    output logic [LWIDTH-1:0]           req_read_len,
    input  logic [DWIDTH-1:0]           rdata,
    input  logic                        rdata_valid,
    output logic                        rdata_ready,
    // Status
    output logic [idx_width(NUM_REQ)-1:0] grant_id,
    output logic                        busy
);

    localparam int unsigned IDW = idx_width(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [IDW-1:0]     owner_q, owner_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [AWIDTH-1:0]  addr_q, addr_d;
    logic [LWIDTH-1:0]  len_q, len_d;
    logic [LWIDTH-1:0]  beat_cnt_q, beat_cnt_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;

    logic [AWIDTH-1:0]  win_addr;
    logic [LWIDTH-1:0]  win_len;
    logic [IDW-1:0]     next_ptr;
    logic               in_idle;
    logic               in_data;
    logic               data_fire;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req       (cli_read_addr_valid),
        .ptr       (rr_ptr_q),
        .gnt       (pick_gnt),
        .idx       (pick_idx),
        .any_valid (pick_any)
    );

    // Select the winning client's address and length.
    always_comb begin
        win_addr = '0;
        win_len  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_gnt[k]) begin
                win_addr = cli_read_addr[k*AWIDTH +: AWIDTH];
                win_len  = cli_read_len[k*LWIDTH +: LWIDTH];
            end
        end
    end

    // Pointer moves just past the owner once its burst completes.
    always_comb begin
        next_ptr = (owner_q == IDW'(NUM_REQ - 1)) ? '0 : owner_q + IDW'(1);
    end

    // Decoded state flags and data-beat handshake.
    always_comb begin
        in_idle   = (state_q == StIdle);
        in_data   = (state_q == StData);
        data_fire = in_data && rdata_valid && cli_rdata_ready[owner_q];
    end

    // Next-state logic for the burst FSM and its bookkeeping registers.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            StIdle: begin
                // The winner always has valid set, so a pick is also a handshake.
                if (pick_any) begin
                    addr_d     = win_addr;
                    len_d      = win_len;
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = StAddr;
                end
            end
            StAddr: begin
                if (req_read_addr_ready) begin
                    if (len_q != '0) begin
                        state_d = StData;
                    end else begin
                        // Zero-length burst: no data phase at all.
                        state_d  = StIdle;
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            StData: begin
                if (data_fire) begin
                    beat_cnt_d = beat_cnt_q + LWIDTH'(1);
                    if (beat_cnt_q == len_q - LWIDTH'(1)) begin
                        state_d  = StIdle;
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and bookkeeping registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Client address accept; gated by rst so nothing is granted while reset is held.
    always_comb begin
        cli_read_addr_ready = pick_gnt & {NUM_REQ{rst && in_idle}};
    end

    // Memory address channel is driven straight from registers.
    always_comb begin
        req_read_addr       = addr_q;
        req_read_len        = len_q;
        req_read_addr_valid = (state_q == StAddr);
    end

    // Data passthrough toward the owner only; memory is held off outside the data phase.
    always_comb begin
        cli_rdata       = in_data ? rdata : '0;
        rdata_ready     = in_data && cli_rdata_ready[owner_q];
        cli_rdata_valid = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cli_rdata_valid[k] = in_data && rdata_valid && (owner_q == IDW'(k));
        end
    end

    // Status outputs.
    always_comb begin
        busy     = !in_idle;
        grant_id = in_idle ? '0 : owner_q;
    end

endmodule

// File: tb/tb_conv2d_read_arbiter.sv
// Directed bench for conv2d_read_arbiter with two clients and a scripted memory.
module tb_conv2d_read_arbiter;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*AW-1:0]  cli_read_addr;
    logic [NR-1:0]     cli_read_addr_valid;
    logic [NR-1:0]     cli_read_addr_ready;
    logic [NR*LW-1:0]  cli_read_len;
    logic [DW-1:0]     cli_rdata;
    logic [NR-1:0]     cli_rdata_valid;
    logic [NR-1:0]     cli_rdata_ready;
    logic [AW-1:0]     req_read_addr;
    logic              req_read_addr_valid;
    logic              req_read_addr_ready;
    logic [LW-1:0]     req_read_len;
    logic [DW-1:0]     rdata;
    logic              rdata_valid;
    logic              rdata_ready;
    logic [0:0]        grant_id;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;
    int waited;

    conv2d_read_arbiter #(
        .NUM_REQ (NR),
        .AWIDTH  (AW),
        .DWIDTH  (DW),
        .LWIDTH  (LW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .cli_read_addr       (cli_read_addr),
        .cli_read_addr_valid (cli_read_addr_valid),
        .cli_read_addr_ready (cli_read_addr_ready),
        .cli_read_len        (cli_read_len),
        .cli_rdata           (cli_rdata),
        .cli_rdata_valid     (cli_rdata_valid),
        .cli_rdata_ready     (cli_rdata_ready),
        .req_read_addr       (req_read_addr),
        .req_read_addr_valid (req_read_addr_valid),
        .req_read_addr_ready (req_read_addr_ready),
        .req_read_len        (req_read_len),
        .rdata               (rdata),
        .rdata_valid         (rdata_valid),
        .rdata_ready         (rdata_ready),
        .grant_id            (grant_id),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one burst for client c from request to completion, checking every cycle.
    // Called just after a falling edge. keep leaves the client's valid high afterwards.
    // abort_at >= 0 asserts reset while that beat index is being presented.
    task automatic serve(input int c, input logic [31:0] a, input logic [31:0] l,
                         input bit keep, input int stall_at, input int stall_n,
                         input int abort_at, output int wcnt);
        logic [NR-1:0] oh;
        logic [31:0]   pat;
        int            b;
        int            stalls;
        bit            stalled;
        oh = 2'b01 << c;
        cli_read_addr[c*AW +: AW] = a;
        cli_read_len[c*LW +: LW]  = l;
        cli_read_addr_valid[c]    = 1'b1;
        wcnt = 0;
        #1;
        while (cli_read_addr_ready == '0 && wcnt < 20) begin
            @(negedge clk);
            #1;
            wcnt++;
        end
        check_eq("addr_ready_winner", cli_read_addr_ready, oh);
        check_eq("mem_valid_before_hs", req_read_addr_valid, 1'b0);
        @(negedge clk);
        if (!keep) cli_read_addr_valid[c] = 1'b0;
        #1;
        check_eq("mem_addr_valid", req_read_addr_valid, 1'b1);
        check_eq("mem_addr", req_read_addr, a);
        check_eq("mem_len", req_read_len, l);
        check_eq("grant_id_addr", grant_id, c);
        check_eq("busy_addr", busy, 1'b1);
        check_eq("no_grant_addr", cli_read_addr_ready, 2'b00);
        check_eq("rdata_ready_addr", rdata_ready, 1'b0);
        req_read_addr_ready = 1'b1;
        @(negedge clk);
        req_read_addr_ready = 1'b0;
        b      = 0;
        stalls = 0;
        while (b < int'(l)) begin
            if (b == abort_at) begin
                cli_read_addr_valid[1] = 1'b1;
                rdata_valid = 1'b1;
                rst = 1'b0;
                #1;
                check_eq("rst_busy", busy, 1'b0);
                check_eq("rst_grant", grant_id, 1'b0);
                check_eq("rst_cli_valid", cli_rdata_valid, 2'b00);
                check_eq("rst_rdata_ready", rdata_ready, 1'b0);
                check_eq("rst_mem_valid", req_read_addr_valid, 1'b0);
                check_eq("rst_addr_ready", cli_read_addr_ready, 2'b00);
                check_eq("rst_mem_addr", req_read_addr, 32'h0);
                check_eq("rst_mem_len", req_read_len, 32'h0);
                rdata_valid = 1'b0;
                cli_read_addr_valid = '0;
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            stalled = (b == stall_at) && (stalls < stall_n);
            pat = 32'hD000_0000 + (c * 32'h1_0000) + b;
            rdata = pat;
            rdata_valid = 1'b1;
            cli_rdata_ready = 2'b11;
            if (stalled) cli_rdata_ready[c] = 1'b0;
            #1;
            check_eq("beat_valid", cli_rdata_valid, oh);
            check_eq("beat_data", cli_rdata, pat);
            check_eq("beat_ready", rdata_ready, !stalled);
            check_eq("beat_busy", busy, 1'b1);
            check_eq("no_grant_data", cli_read_addr_ready, 2'b00);
            if (stalled) stalls++;
            else b++;
            @(negedge clk);
        end
        rdata_valid = 1'b0;
        cli_rdata_ready = 2'b11;
        #1;
        check_eq("busy_done", busy, 1'b0);
        check_eq("grant_idle", grant_id, 1'b0);
        check_eq("cli_valid_idle", cli_rdata_valid, 2'b00);
        check_eq("rdata_ready_idle", rdata_ready, 1'b0);
    endtask

    initial begin
        rst                 = 1'b0;
        cli_read_addr       = '0;
        cli_read_len        = '0;
        cli_read_addr_valid = 2'b01;
        cli_rdata_ready     = 2'b11;
        req_read_addr_ready = 1'b0;
        rdata               = 32'hFFFF_FFFF;
        rdata_valid         = 1'b1;
        #1;
        check_eq("reset_addr_ready", cli_read_addr_ready, 2'b00);
        check_eq("reset_busy", busy, 1'b0);
        check_eq("reset_grant", grant_id, 1'b0);
        check_eq("reset_mem_valid", req_read_addr_valid, 1'b0);
        check_eq("reset_rdata_ready", rdata_ready, 1'b0);
        check_eq("reset_cli_valid", cli_rdata_valid, 2'b00);
        repeat (2) @(negedge clk);
        rdata_valid = 1'b0;
        rst = 1'b1;

        // Single client, len 9; rr_ptr then points at client1.
        serve(0, 32'h100, 32'd9, 1'b0, -1, 0, -1, waited);
        cli_read_addr[AW +: AW] = 32'h180;
        cli_read_len[LW +: LW]  = 32'd1;
        cli_read_addr_valid[1]  = 1'b1;
        serve(1, 32'h180, 32'd1, 1'b0, -1, 0, -1, waited);
        check_eq("gap_after_ptr", waited, 0);

        // Simultaneous requests from reset: client0 first, then client1 after one IDLE cycle.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cli_read_addr[AW +: AW] = 32'h200;
        cli_read_len[LW +: LW]  = 32'd2;
        cli_read_addr_valid[1]  = 1'b1;
        serve(0, 32'h140, 32'd2, 1'b0, -1, 0, -1, waited);
        serve(1, 32'h200, 32'd2, 1'b0, -1, 0, -1, waited);
        check_eq("gap_second_grant", waited, 0);

        // Both hold valid across four bursts: grants alternate 0,1,0,1.
        cli_read_addr[AW +: AW] = 32'h240;
        cli_read_len[LW +: LW]  = 32'd3;
        cli_read_addr_valid     = 2'b11;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) serve(0, 32'h400 + i, 32'd3, 1'b1, -1, 0, -1, waited);
            else            serve(1, 32'h240, 32'd3, 1'b1, -1, 0, -1, waited);
        end
        cli_read_addr_valid = 2'b00;

        // Owner stalls five cycles mid-burst.
        serve(0, 32'h500, 32'd6, 1'b0, 2, 5, -1, waited);

        // Zero-length burst from client1, then client0 wins the next contest.
        serve(1, 32'h600, 32'd0, 1'b0, -1, 0, -1, waited);
        cli_read_addr[AW +: AW] = 32'h640;
        cli_read_len[LW +: LW]  = 32'd1;
        cli_read_addr_valid[1]  = 1'b1;
        serve(0, 32'h680, 32'd1, 1'b0, -1, 0, -1, waited);
        cli_read_addr_valid = 2'b00;

        // Reset during beat 4 of a len-9 burst; afterwards rr_ptr is back at 0.
        serve(0, 32'h700, 32'd9, 1'b0, -1, 0, 3, waited);
        cli_read_addr[AW +: AW] = 32'h740;
        cli_read_len[LW +: LW]  = 32'd2;
        cli_read_addr_valid[1]  = 1'b1;
        serve(0, 32'h780, 32'd2, 1'b0, -1, 0, -1, waited);
        serve(1, 32'h740, 32'd2, 1'b0, -1, 0, -1, waited);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv2d_read_arbiter.md
Name: conv2D_read_arbiter

Overview:
- Round-robin arbiter that shares the single io_mem read request path (address channel plus read-data channel) among NUM_REQ accelerator engines, e.g. the conv2D compute block and a weight/bias prefetcher.
- Bursts are non-overlapping: one burst is outstanding at a time and is locked to its owner until its last beat is delivered.
- Sits between the engines' read ports and the io_mem read interface.

Parameters:
- NUM_REQ, 2, number of requesting engines (2..8).
- AWIDTH, 32, address width.
- DWIDTH, 32, data beat width.
- LWIDTH, 32, burst length field width.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cli_read_addr  in  NUM_REQ*AWIDTH  per-client burst address, client k at bits [k*AWIDTH +: AWIDTH].
- cli_read_addr_valid  in  NUM_REQ  per-client request valid.
- cli_read_addr_ready  out  NUM_REQ  per-client request accept.
- cli_read_len  in  NUM_REQ*LWIDTH  per-client burst length in beats.
- cli_rdata  out  DWIDTH  read data, broadcast to all clients.
- cli_rdata_valid  out  NUM_REQ  data valid, asserted only toward the owner.
- cli_rdata_ready  in  NUM_REQ  per-client data ready.
- req_read_addr  out  AWIDTH  memory burst address.
- req_read_addr_valid  out  1  memory address valid.
- req_read_addr_ready  in  1  memory address accept.
- req_read_len  out  LWIDTH  memory burst length.
- rdata  in  DWIDTH  memory read data.
- rdata_valid  in  1  memory data valid.
- rdata_ready  out  1  memory data ready.
- grant_id  out  max(1,$clog2(NUM_REQ))  current owner; 0 when idle.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- States: IDLE, ADDR, DATA. Registers: state, owner, rr_ptr, addr_q, len_q, beat_cnt.

IDLE:
- Winner is the first client with valid set, searching from rr_ptr upward with wrap.
- Only the winner gets cli_read_addr_ready=1, combinationally; all other readies are 0.
- On the handshake: latch addr and len, set owner to the winner, clear beat_cnt, go to ADDR.
- No valid requester: stay in IDLE.

ADDR:
- req_read_addr_valid=1 (registered), with req_read_addr=addr_q and req_read_len=len_q.
- Latency: memory address valid is asserted exactly 1 cycle after the client handshake.
- On req_read_addr_ready: go to DATA if len_q != 0; if len_q == 0, go to IDLE and advance rr_ptr.
- Valid and addr/len are held stable until accepted.

DATA:
- Combinational passthrough: cli_rdata=rdata, cli_rdata_valid[owner]=rdata_valid, rdata_ready=cli_rdata_ready[owner].
- All other client valids are 0.
- Each fire (rdata_valid & rdata_ready) increments beat_cnt.
- A fire with beat_cnt == len_q-1 is the last beat: go to IDLE and set rr_ptr = owner+1 mod NUM_REQ.

Other rules:
- Outside DATA, rdata_ready=0 and all cli_rdata_valid are 0; memory data is held off and never dropped.
- No new grant is issued while in ADDR or DATA. A requester's valid may stay high across other clients' bursts.
- Simultaneous last beat and new requests: the new grant is evaluated in the next cycle (IDLE), against the updated rr_ptr.
- beat_cnt is LWIDTH wide and does not wrap, since it is compared against len_q.

Reset:
- While rst is low, regardless of state: state=IDLE, owner=0, rr_ptr=0, beat_cnt=0, addr_q=0, len_q=0.
- All outputs 0, including grant_id and busy.
- A reset mid-burst abandons the burst; the memory side is expected to be reset together with the arbiter.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, ADDR=2'd1, DATA=2'd2) and the default LWIDTH constant.
- One sub-module, rr_priority_pick: combinational picker taking req[NUM_REQ] and ptr, producing a onehot grant plus an index and an any_valid flag.
- All sequential logic stays in conv2D_read_arbiter.

Test Plan:
- Client0 requests addr 0x100, len 9, memory always ready → req_read_addr_valid 1 cycle after the handshake; 9 beats reach client0 only; busy drops after beat 9; rr_ptr=1.
- Client0 and client1 both request in the same cycle from reset → client0 served first, then client1 with no idle gap beyond one IDLE cycle; grant_id sequence 0,1.
- Both clients hold valid high for 4 bursts of len 3 → grants alternate 0,1,0,1.
- Owner drops cli_rdata_ready for 5 cycles mid-burst → rdata_ready=0 during the stall; no beat lost or duplicated; beat_cnt resumes correctly.
- Client1 requests len 0 → one address handshake, no data phase, returns to IDLE; the next grant goes to client0.
- rst asserted during beat 4 of a len-9 burst → outputs clear immediately (asynchronous); after release the arbiter is IDLE, rr_ptr=0, and a new request is granted normally.
